// File: rtl/fm_read_sequencer_pkg.sv
// Shared widths, read-type codes and FSM encoding for the feature-map read sequencer.
package fm_read_sequencer_pkg;

    localparam int unsigned DATA_WIDTH      = 16;
    localparam int unsigned PARA_Y          = 3;
    localparam int unsigned READ_ADDR_WIDTH = 10;
    localparam int unsigned FM_SIZE_WIDTH   = 6;
    localparam int unsigned RAM_LATENCY     = 1;

    localparam logic [1:0] RD_CONV = 2'd0;
    localparam logic [1:0] RD_POOL = 2'd1;
    localparam logic [1:0] RD_FC   = 2'd2;
    localparam logic [1:0] RD_RSVD = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } state_t;

endpackage

// File: rtl/fm_read_skid_fifo.sv
// Two-entry fall-through FIFO: an incoming word is visible on head in the cycle it arrives
// when the FIFO is empty, and is only stored if it is not consumed in that same cycle.
module fm_read_skid_fifo
    import fm_read_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = PARA_Y * DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             valid,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             empty;
    logic             pop;
    logic             store;
    logic             consume;

    assign empty   = (count_q == 2'd0);
    assign valid   = !empty || push;
    assign head    = empty ? push_data : mem_q[rd_ptr_q];
    assign pop     = valid && pop_ready;
    assign store   = push && !(empty && pop);
    assign consume = pop && !empty;
    assign count   = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (store) wr_ptr_q <= !wr_ptr_q;
            if (consume) rd_ptr_q <= !rd_ptr_q;
            count_q <= count_q + {1'b0, store} - {1'b0, consume};
        end
    end

    always_ff @(posedge clk) begin
        if (store) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/fm_read_sequencer.sv
// Feature-map RAM read initiator: walks a CONV/POOL/FC address pattern and streams the
// returned words out with back-pressure, never issuing more reads than the FIFO can absorb.
module fm_read_sequencer
    import fm_read_sequencer_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [1:0]                         cfg_read_type,
    input  logic [READ_ADDR_WIDTH-1:0]         cfg_addr_start,
    input  logic [READ_ADDR_WIDTH-1:0]         cfg_addr_end,
    input  logic [READ_ADDR_WIDTH-1:0]         cfg_addr_step,
    input  logic [FM_SIZE_WIDTH-1:0]           cfg_sub_count,
    output logic                               busy,
    output logic                               done,
    output logic                               ram_ena_r,
    output logic [1:0]                         ram_read_type,
    output logic [READ_ADDR_WIDTH-1:0]         ram_addr_read,
    output logic [READ_ADDR_WIDTH-1:0]         ram_sub_addr_read,
    input  logic [PARA_Y*DATA_WIDTH-1:0]       ram_dout,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [PARA_Y*DATA_WIDTH-1:0]       out_data,
    output logic                               out_last
);

    localparam int unsigned AW = READ_ADDR_WIDTH;
    localparam int unsigned FW = FM_SIZE_WIDTH;
    localparam int unsigned DW = PARA_Y * DATA_WIDTH;

    state_t          state_q, state_d;
    logic [1:0]      type_q;
    logic [AW-1:0]   addr_q, end_q, step_q;
    logic [FW-1:0]   sub_q, sub_last_q;
    logic            inflight_q, inflight_last_q;
    logic [1:0]      fifo_count;
    logic            fifo_valid;
    logic [DW:0]     fifo_head;
    logic            accept, empty_job, credit_ok, issue, row_done, final_read, pop;
    logic [AW:0]     next_addr;

    assign accept    = start && (state_q == StIdle);
    assign empty_job = (cfg_read_type == RD_RSVD) || (cfg_addr_end < cfg_addr_start);
    assign credit_ok = ({1'b0, fifo_count} + {2'b00, inflight_q}) < 3'd2;
    assign row_done  = (type_q != RD_CONV) || (sub_q == sub_last_q);
    // Extra bit catches the carry so the walk stops instead of wrapping to address 0.
    assign next_addr  = {1'b0, addr_q} + {1'b0, step_q};
    assign final_read = row_done && (next_addr[AW] || (next_addr[AW-1:0] > end_q));

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = empty_job ? StDone : StIssue;
            end
            StIssue: begin
                issue = credit_ok;
                if (issue && final_read) state_d = StDrain;
            end
            StDrain: begin
                if (pop && fifo_head[DW]) state_d = StDone;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            type_q          <= '0;
            addr_q          <= '0;
            end_q           <= '0;
            step_q          <= '0;
            sub_q           <= '0;
            sub_last_q      <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            inflight_q      <= issue;
            inflight_last_q <= issue && final_read;
            if (accept) begin
                type_q     <= cfg_read_type;
                end_q      <= cfg_addr_end;
                step_q     <= (cfg_addr_step == '0) ? AW'(1) : cfg_addr_step;
                sub_last_q <= (cfg_sub_count == '0) ? '0 : cfg_sub_count - FW'(1);
                if (!empty_job) begin
                    addr_q <= cfg_addr_start;
                    sub_q  <= '0;
                end
            end else if (issue && !final_read) begin
                if (!row_done) begin
                    sub_q <= sub_q + FW'(1);
                end else begin
                    sub_q  <= '0;
                    addr_q <= next_addr[AW-1:0];
                end
            end
        end
    end

    fm_read_skid_fifo #(
        .WIDTH (DW + 1)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data ({inflight_last_q, ram_dout}),
        .pop_ready (out_ready),
        .valid     (fifo_valid),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign pop               = fifo_valid && out_ready;
    assign busy              = (state_q != StIdle);
    assign ram_ena_r         = issue;
    assign ram_read_type     = type_q;
    assign ram_addr_read     = addr_q;
    assign ram_sub_addr_read = {{(AW - FW){1'b0}}, sub_q};
    assign out_valid         = fifo_valid;
    assign out_data          = fifo_valid ? fifo_head[DW-1:0] : '0;
    assign out_last          = fifo_valid && fifo_head[DW];

endmodule

// File: tb/tb_fm_read_sequencer.sv
// Directed bench for fm_read_sequencer with a one-cycle-latency RAM model returning tagged words.
module tb_fm_read_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  cfg_read_type;
    logic [9:0]  cfg_addr_start, cfg_addr_end, cfg_addr_step;
    logic [5:0]  cfg_sub_count;
    logic        busy, done, ram_ena_r;
    logic [1:0]  ram_read_type;
    logic [9:0]  ram_addr_read, ram_sub_addr_read;
    logic [47:0] ram_dout;
    logic        out_valid, out_ready, out_last;
    logic [47:0] out_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fm_read_sequencer dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .cfg_read_type     (cfg_read_type),
        .cfg_addr_start    (cfg_addr_start),
        .cfg_addr_end      (cfg_addr_end),
        .cfg_addr_step     (cfg_addr_step),
        .cfg_sub_count     (cfg_sub_count),
        .busy              (busy),
        .done              (done),
        .ram_ena_r         (ram_ena_r),
        .ram_read_type     (ram_read_type),
        .ram_addr_read     (ram_addr_read),
        .ram_sub_addr_read (ram_sub_addr_read),
        .ram_dout          (ram_dout),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_last          (out_last)
    );

    // RAM contents: three float16-style lanes tagged with the row address and column offset.
    function automatic logic [47:0] ram_word(input int a, input int s);
        logic [15:0] a16, s16;
        a16 = 16'(a);
        s16 = 16'(s);
        return {16'h3c00 + a16, 16'h4000 + s16, 16'h4200 ^ {a16[9:0], s16[5:0]}};
    endfunction

    always @(posedge clk) begin
        if (ram_ena_r) ram_dout <= ram_word(int'(ram_addr_read), int'(ram_sub_addr_read));
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [1:0] t, input int s, input int e, input int st,
                           input int sc);
        cfg_read_type  = t;
        cfg_addr_start = 10'(s);
        cfg_addr_end   = 10'(e);
        cfg_addr_step  = 10'(st);
        cfg_sub_count  = 6'(sc);
    endtask

    int          issued, beats;
    logic        seen_done, stalled;
    logic [47:0] held;
    int          fc_addr[3];

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        ram_dout  = '0;
        set_cfg(2'd0, 0, 0, 0, 0);
        fc_addr = '{0, 3, 6};

        // Reset state
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_ena", 64'(ram_ena_r), 64'(0));
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_data", 64'(out_data), 64'(0));
        chk("rst_last", 64'(out_last), 64'(0));
        chk("rst_addr", 64'(ram_addr_read), 64'(0));
        chk("rst_type", 64'(ram_read_type), 64'(0));
        rst_n = 1'b1;

        // CONV: one row at 3, two columns
        tick();
        start = 1'b1;
        set_cfg(2'd0, 3, 3, 1, 2);
        #1;
        chk("conv_c0_busy", 64'(busy), 64'(0));
        tick();
        start = 1'b0;
        #1;
        chk("conv_c1_ena", 64'(ram_ena_r), 64'(1));
        chk("conv_c1_addr", 64'(ram_addr_read), 64'(3));
        chk("conv_c1_sub", 64'(ram_sub_addr_read), 64'(0));
        chk("conv_c1_busy", 64'(busy), 64'(1));
        chk("conv_c1_valid", 64'(out_valid), 64'(0));
        tick();
        chk("conv_c2_ena", 64'(ram_ena_r), 64'(1));
        chk("conv_c2_sub", 64'(ram_sub_addr_read), 64'(1));
        chk("conv_c2_valid", 64'(out_valid), 64'(1));
        chk("conv_c2_data", 64'(out_data), 64'(ram_word(3, 0)));
        chk("conv_c2_last", 64'(out_last), 64'(0));
        tick();
        chk("conv_c3_ena", 64'(ram_ena_r), 64'(0));
        chk("conv_c3_data", 64'(out_data), 64'(ram_word(3, 1)));
        chk("conv_c3_last", 64'(out_last), 64'(1));
        chk("conv_c3_done", 64'(done), 64'(0));
        tick();
        chk("conv_c4_done", 64'(done), 64'(1));
        chk("conv_c4_valid", 64'(out_valid), 64'(0));
        tick();
        chk("conv_c5_done", 64'(done), 64'(0));
        chk("conv_c5_busy", 64'(busy), 64'(0));
        chk("conv_c5_hold_addr", 64'(ram_addr_read), 64'(3));
        chk("conv_c5_hold_sub", 64'(ram_sub_addr_read), 64'(1));

        // POOL: rows 9 and 10, sub_count ignored
        start = 1'b1;
        set_cfg(2'd1, 9, 10, 1, 5);
        tick();
        start = 1'b0;
        #1;
        chk("pool_c1_type", 64'(ram_read_type), 64'(1));
        chk("pool_c1_addr", 64'(ram_addr_read), 64'(9));
        chk("pool_c1_ena", 64'(ram_ena_r), 64'(1));
        tick();
        chk("pool_c2_addr", 64'(ram_addr_read), 64'(10));
        chk("pool_c2_sub", 64'(ram_sub_addr_read), 64'(0));
        chk("pool_c2_data", 64'(out_data), 64'(ram_word(9, 0)));
        tick();
        chk("pool_c3_data", 64'(out_data), 64'(ram_word(10, 0)));
        chk("pool_c3_last", 64'(out_last), 64'(1));
        tick();
        chk("pool_c4_done", 64'(done), 64'(1));
        tick();

        // FC: rows 0,3,6 with ready pattern 1,0,0,1
        start = 1'b1;
        set_cfg(2'd2, 0, 8, 3, 0);
        tick();
        start     = 1'b0;
        issued    = 0;
        beats     = 0;
        seen_done = 1'b0;
        stalled   = 1'b0;
        held      = '0;
        for (int i = 0; i < 40 && !seen_done; i++) begin
            out_ready = ((i % 4) == 0) || ((i % 4) == 3);
            #1;
            if (ram_ena_r) begin
                chk("fc_addr", 64'(ram_addr_read), 64'(issued < 3 ? fc_addr[issued] : 999));
                issued++;
            end
            chk("fc_outstanding_le2", 64'((issued - beats) <= 2), 64'(1));
            if (stalled) begin
                chk("fc_hold_valid", 64'(out_valid), 64'(1));
                chk("fc_hold_data", 64'(out_data), 64'(held));
            end
            if (out_valid && out_ready) begin
                chk("fc_data", 64'(out_data),
                    64'(ram_word(beats < 3 ? fc_addr[beats] : 999, 0)));
                chk("fc_last", 64'(out_last), 64'(beats == 2));
                beats++;
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
            if (done) seen_done = 1'b1;
            tick();
        end
        chk("fc_issued", 64'(issued), 64'(3));
        chk("fc_beats", 64'(beats), 64'(3));
        chk("fc_done_seen", 64'(seen_done), 64'(1));
        chk("fc_idle_after", 64'(busy), 64'(0));
        out_ready = 1'b1;

        // Empty (end < start) and reserved-type jobs
        for (int j = 0; j < 2; j++) begin
            start = 1'b1;
            if (j == 0) set_cfg(2'd0, 5, 2, 1, 1);
            else        set_cfg(2'd3, 0, 5, 1, 1);
            tick();
            start = 1'b0;
            #1;
            chk("empty_c1_done", 64'(done), 64'(1));
            chk("empty_c1_ena", 64'(ram_ena_r), 64'(0));
            chk("empty_c1_valid", 64'(out_valid), 64'(0));
            tick();
            chk("empty_c2_done", 64'(done), 64'(0));
            chk("empty_c2_busy", 64'(busy), 64'(0));
            chk("empty_c2_valid", 64'(out_valid), 64'(0));
        end

        // Address overflow: 1020 + 4 carries out of 10 bits
        start = 1'b1;
        set_cfg(2'd1, 1020, 1023, 4, 1);
        tick();
        start = 1'b0;
        #1;
        chk("ovf_c1_ena", 64'(ram_ena_r), 64'(1));
        chk("ovf_c1_addr", 64'(ram_addr_read), 64'(1020));
        tick();
        chk("ovf_c2_ena", 64'(ram_ena_r), 64'(0));
        chk("ovf_c2_addr", 64'(ram_addr_read), 64'(1020));
        chk("ovf_c2_data", 64'(out_data), 64'(ram_word(1020, 0)));
        chk("ovf_c2_last", 64'(out_last), 64'(1));
        tick();
        chk("ovf_c3_done", 64'(done), 64'(1));
        chk("ovf_c3_ena", 64'(ram_ena_r), 64'(0));
        tick();

        // Reset in the middle of a stalled CONV job with two beats buffered
        out_ready = 1'b0;
        start     = 1'b1;
        set_cfg(2'd0, 4, 6, 1, 3);
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("stall_c3_ena", 64'(ram_ena_r), 64'(0));
        tick();
        chk("stall_c4_ena", 64'(ram_ena_r), 64'(0));
        chk("stall_c4_data", 64'(out_data), 64'(ram_word(4, 0)));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_addr", 64'(ram_addr_read), 64'(0));
        tick();
        chk("mid_rst_done", 64'(done), 64'(0));
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("post_rst_done", 64'(done), 64'(0));
        // step=0 and sub_count=0 must behave as 1
        start = 1'b1;
        set_cfg(2'd0, 7, 7, 0, 0);
        tick();
        start = 1'b0;
        #1;
        chk("restart_c1_addr", 64'(ram_addr_read), 64'(7));
        chk("restart_c1_sub", 64'(ram_sub_addr_read), 64'(0));
        tick();
        chk("restart_c2_ena", 64'(ram_ena_r), 64'(0));
        chk("restart_c2_data", 64'(out_data), 64'(ram_word(7, 0)));
        chk("restart_c2_last", 64'(out_last), 64'(1));
        tick();
        chk("restart_c3_done", 64'(done), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
